// File: rtl/spi_slave_regfile.sv
// SPI slave with an internal register bank, oversampled in the PCLK domain.
// Frames carry one command word (R/W + start address) followed by auto-incrementing data words.
module spi_slave_regfile #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 3,
   parameter int unsigned CS_W       = 3,
   parameter int unsigned SLAVE_ID   = 7,
   parameter bit          CPOL       = 1'b0,
   parameter bit          CPHA       = 1'b0,
   parameter int unsigned RESET_DATA = 33
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              spi_clk,
   input  logic [CS_W-1:0]   CS,
   input  logic              MOSI,
   output logic              MISO,
   output logic              miso_oe,
   output logic              reg_wr_pulse,
   output logic [ADDR_W-1:0] reg_wr_addr,
   output logic [DATA_W-1:0] reg_wr_data,
   output logic              frame_done,
   output logic              frame_err
);

   localparam int unsigned       CntW     = $clog2(DATA_W) + 1;
   localparam int                Depth    = 1 << ADDR_W;
   localparam logic [CntW-1:0]   LastBit  = CntW'(DATA_W - 1);
   localparam logic [DATA_W-1:0] ResetVal = DATA_W'(RESET_DATA);
   localparam logic [CS_W-1:0]   SelId    = CS_W'(SLAVE_ID);

   typedef enum logic [1:0] {StIdle, StCmd, StWr, StRd} state_e;

   logic              sclk_s1_q, sclk_s2_q, sclk_s3_q;
   logic [CS_W-1:0]   cs_s1_q, cs_s2_q;
   logic              mosi_s1_q, mosi_s2_q;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] tx_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] regs_q [Depth];
   logic              miso_q;
   logic              oe_q;
   logic              wr_pulse_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              done_q;
   logic              err_q;

   logic              selected;
   logic              lead_ev;
   logic              trail_ev;
   logic              sample_ev;
   logic              shift_ev;
   logic              word_end;
   logic [DATA_W-1:0] rx_word;
   logic [ADDR_W-1:0] cmd_addr;

   // Third spi_clk flop holds the previous synced level for edge detection.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         sclk_s1_q <= CPOL;
         sclk_s2_q <= CPOL;
         sclk_s3_q <= CPOL;
         cs_s1_q   <= '0;
         cs_s2_q   <= '0;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         sclk_s1_q <= spi_clk;
         sclk_s2_q <= sclk_s1_q;
         sclk_s3_q <= sclk_s2_q;
         cs_s1_q   <= CS;
         cs_s2_q   <= cs_s1_q;
         mosi_s1_q <= MOSI;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   always_comb begin
      selected  = (cs_s2_q == SelId);
      lead_ev   = (sclk_s2_q != CPOL) && (sclk_s3_q == CPOL);
      trail_ev  = (sclk_s2_q == CPOL) && (sclk_s3_q != CPOL);
      sample_ev = CPHA ? trail_ev : lead_ev;
      shift_ev  = CPHA ? lead_ev : trail_ev;
      word_end  = (cnt_q == LastBit);
      rx_word   = {rx_q[DATA_W-2:0], mosi_s2_q};
      cmd_addr  = rx_word[ADDR_W-1:0];
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         addr_q     <= '0;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
         wr_pulse_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         for (int i = 0; i < Depth; i++) begin
            regs_q[i] <= ResetVal;
         end
      end else begin
         wr_pulse_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         if (state_q == StIdle) begin
            if (selected) begin
               state_q <= StCmd;
               cnt_q   <= '0;
               tx_q    <= '0;
               miso_q  <= 1'b0;
               oe_q    <= 1'b1;
            end
         end else if (!selected) begin
            // A partial word is dropped; only the error pulse records it.
            state_q <= StIdle;
            oe_q    <= 1'b0;
            miso_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= (cnt_q != '0);
         end else if (sample_ev) begin
            rx_q  <= rx_word;
            cnt_q <= word_end ? '0 : cnt_q + CntW'(1);
            if (word_end) begin
               case (state_q)
                  StCmd: begin
                     if (rx_word[DATA_W-1]) begin
                        state_q <= StRd;
                        tx_q    <= regs_q[cmd_addr];
                        addr_q  <= cmd_addr + ADDR_W'(1);
                     end else begin
                        state_q <= StWr;
                        addr_q  <= cmd_addr;
                     end
                  end
                  StWr: begin
                     regs_q[addr_q] <= rx_word;
                     wr_pulse_q     <= 1'b1;
                     wr_addr_q      <= addr_q;
                     wr_data_q      <= rx_word;
                     addr_q         <= addr_q + ADDR_W'(1);
                  end
                  StRd: begin
                     tx_q   <= regs_q[addr_q];
                     addr_q <= addr_q + ADDR_W'(1);
                  end
                  default: begin
                  end
               endcase
            end
         end else if (shift_ev) begin
            miso_q <= tx_q[DATA_W-1];
            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   assign MISO         = miso_q;
   assign miso_oe      = oe_q;
   assign reg_wr_pulse = wr_pulse_q;
   assign reg_wr_addr  = wr_addr_q;
   assign reg_wr_data  = wr_data_q;
   assign frame_done   = done_q;
   assign frame_err    = err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: one instance per SPI mode (index = {CPOL, CPHA}),
// driven by a bit-banged master with table-driven frames plus hand-written corner cases.
module tb_spi_slave_regfile;

   localparam int Half = 80;

   typedef struct {
      int         mode;
      logic [7:0] cmd;
      int         n;
      logic [7:0] d  [3];
      logic [7:0] rx [3];
      int         nwr;
      logic [2:0] a  [3];
   } vec_t;

   logic       pclk = 1'b0;
   logic       presetn;
   logic       sclk     [4];
   logic [2:0] cs       [4];
   logic       mosi;
   logic       miso     [4];
   logic       oe       [4];
   logic       wr_pulse [4];
   logic [2:0] wr_addr  [4];
   logic [7:0] wr_data  [4];
   logic       done     [4];
   logic       err      [4];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_cnt [4];
   int          err_cnt  [4];
   int          unstable;
   int          oe_low;
   logic [12:0] wlog [$];
   logic [7:0]  tx_buf [4];
   logic [7:0]  rx_buf [4];
   vec_t        vecs [14];

   always #5 pclk = ~pclk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_regfile #(
         .DATA_W    (8),
         .ADDR_W    (3),
         .CS_W      (3),
         .SLAVE_ID  (7),
         .CPOL      (g >= 2),
         .CPHA      (g % 2 == 1),
         .RESET_DATA(33)
      ) u_dut (
         .PCLK        (pclk),
         .PRESETn     (presetn),
         .spi_clk     (sclk[g]),
         .CS          (cs[g]),
         .MOSI        (mosi),
         .MISO        (miso[g]),
         .miso_oe     (oe[g]),
         .reg_wr_pulse(wr_pulse[g]),
         .reg_wr_addr (wr_addr[g]),
         .reg_wr_data (wr_data[g]),
         .frame_done  (done[g]),
         .frame_err   (err[g])
      );
   end

   always @(negedge pclk) begin
      for (int m = 0; m < 4; m++) begin
         if (wr_pulse[m] === 1'b1) wlog.push_back({2'(m), wr_addr[m], wr_data[m]});
         if (done[m] === 1'b1) done_cnt[m]++;
         if (err[m] === 1'b1) err_cnt[m]++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Master-side sample: capture MISO, then confirm it holds across the slave's reaction window.
   task automatic sample(input int m, output logic r);
      r = miso[m];
      if (oe[m] !== 1'b1) oe_low++;
      #50;
      if (miso[m] !== r) unstable++;
   endtask

   task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      logic cpol;
      logic cpha;
      logic r;
      cpol = (m >= 2);
      cpha = (m % 2 == 1);
      rx   = '0;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) mosi = tx[7-i];
         #Half;
         sclk[m] = ~cpol;
         if (cpha) mosi = tx[7-i];
         else sample(m, r);
         #Half;
         sclk[m] = cpol;
         if (cpha) sample(m, r);
         rx[7-i] = r;
      end
   endtask

   task automatic run_frame(input int m, input int nbytes, input int tail);
      logic [7:0] r;
      cs[m] = 3'd7;
      for (int i = 0; i < nbytes; i++) begin
         xfer(m, tx_buf[i], 8, r);
         rx_buf[i] = r;
      end
      if (tail > 0) xfer(m, tx_buf[nbytes], tail, r);
      #Half;
      cs[m] = 3'd0;
      #200;
   endtask

   task automatic set_vec(input int idx, input int mode, input logic [7:0] cmd, input int n,
                          input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                          input int nwr, input logic [2:0] a0, input logic [2:0] a1,
                          input logic [2:0] a2);
      vecs[idx].mode  = mode;
      vecs[idx].cmd   = cmd;
      vecs[idx].n     = n;
      vecs[idx].d[0]  = d0;
      vecs[idx].d[1]  = d1;
      vecs[idx].d[2]  = d2;
      vecs[idx].rx[0] = r0;
      vecs[idx].rx[1] = r1;
      vecs[idx].rx[2] = r2;
      vecs[idx].nwr   = nwr;
      vecs[idx].a[0]  = a0;
      vecs[idx].a[1]  = a1;
      vecs[idx].a[2]  = a2;
   endtask

   task automatic check_idle(input int m, input string tag);
      check($sformatf("%s m%0d MISO", tag, m), 32'(miso[m]), 0);
      check($sformatf("%s m%0d miso_oe", tag, m), 32'(oe[m]), 0);
      check($sformatf("%s m%0d reg_wr_pulse", tag, m), 32'(wr_pulse[m]), 0);
      check($sformatf("%s m%0d reg_wr_addr", tag, m), 32'(wr_addr[m]), 0);
      check($sformatf("%s m%0d reg_wr_data", tag, m), 32'(wr_data[m]), 0);
      check($sformatf("%s m%0d frame_done", tag, m), 32'(done[m]), 0);
      check($sformatf("%s m%0d frame_err", tag, m), 32'(err[m]), 0);
   endtask

   initial begin
      int         m;
      int         d0;
      int         e0;
      logic [7:0] r;

      //            idx mode cmd    n  mosi data             expected miso        nwr addrs
      set_vec(0,  0, 8'h82, 1, 8'hFF, 8'hFF, 8'hFF, 8'h21, 8'h00, 8'h00, 0, 0, 0, 0);
      set_vec(1,  3, 8'h05, 3, 8'hA5, 8'h3C, 8'h99, 8'h00, 8'h00, 8'h00, 3, 5, 6, 7);
      set_vec(2,  3, 8'h06, 3, 8'hA5, 8'h3C, 8'h99, 8'h00, 8'h00, 8'h00, 3, 6, 7, 0);
      set_vec(3,  3, 8'h86, 3, 8'hFF, 8'hFF, 8'hFF, 8'hA5, 8'h3C, 8'h99, 0, 0, 0, 0);
      set_vec(4,  3, 8'h85, 1, 8'hFF, 8'hFF, 8'hFF, 8'hA5, 8'h00, 8'h00, 0, 0, 0, 0);
      set_vec(5,  1, 8'h03, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0);
      set_vec(6,  1, 8'h83, 1, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 8'h00, 8'h00, 0, 0, 0, 0);
      set_vec(7,  2, 8'h03, 1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0);
      set_vec(8,  2, 8'h83, 1, 8'hFF, 8'hFF, 8'hFF, 8'h5A, 8'h00, 8'h00, 0, 0, 0, 0);
      set_vec(9,  2, 8'h84, 1, 8'hFF, 8'hFF, 8'hFF, 8'h21, 8'h00, 8'h00, 0, 0, 0, 0);
      set_vec(10, 0, 8'h80, 2, 8'hFF, 8'hFF, 8'hFF, 8'h21, 8'h21, 8'h00, 0, 0, 0, 0);
      set_vec(11, 0, 8'h7B, 1, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 3, 0, 0);
      set_vec(12, 0, 8'hF3, 2, 8'hFF, 8'hFF, 8'hFF, 8'hC3, 8'h21, 8'h00, 0, 0, 0, 0);
      set_vec(13, 1, 8'h87, 2, 8'h00, 8'h00, 8'h00, 8'h21, 8'h21, 8'h00, 0, 0, 0, 0);

      mosi    = 1'b0;
      presetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sclk[i] = (i >= 2);
         cs[i]   = 3'd0;
      end
      #2 presetn = 1'b0;
      #30;
      for (int i = 0; i < 4; i++) check_idle(i, "reset");
      @(negedge pclk);
      presetn = 1'b1;
      #100;

      for (int v = 0; v < 14; v++) begin
         m         = vecs[v].mode;
         tx_buf[0] = vecs[v].cmd;
         for (int i = 0; i < 3; i++) tx_buf[i+1] = vecs[v].d[i];
         wlog.delete();
         d0       = done_cnt[m];
         e0       = err_cnt[m];
         unstable = 0;
         oe_low   = 0;
         run_frame(m, 1 + vecs[v].n, 0);
         check($sformatf("v%0d cmd-phase miso", v), 32'(rx_buf[0]), 0);
         for (int i = 0; i < vecs[v].n; i++)
            check($sformatf("v%0d rx%0d", v, i), 32'(rx_buf[i+1]), 32'(vecs[v].rx[i]));
         check($sformatf("v%0d write count", v), 32'(wlog.size()), 32'(vecs[v].nwr));
         for (int i = 0; i < vecs[v].nwr && i < wlog.size(); i++)
            check($sformatf("v%0d write%0d", v, i), 32'(wlog[i]),
                  32'({2'(m), vecs[v].a[i], vecs[v].d[i]}));
         check($sformatf("v%0d frame_done", v), 32'(done_cnt[m] - d0), 1);
         check($sformatf("v%0d frame_err", v), 32'(err_cnt[m] - e0), 0);
         check($sformatf("v%0d miso stable at sample", v), 32'(unstable), 0);
         check($sformatf("v%0d miso_oe during frame", v), 32'(oe_low), 0);
      end

      // Frame ends right after the command word: done without error, nothing written.
      wlog.delete();
      d0 = done_cnt[0];
      e0 = err_cnt[0];
      tx_buf[0] = 8'h01;
      run_frame(0, 1, 0);
      check("cmd-only done", 32'(done_cnt[0] - d0), 1);
      check("cmd-only err", 32'(err_cnt[0] - e0), 0);
      check("cmd-only writes", 32'(wlog.size()), 0);

      // CS drops after 4 bits of a data word: error pulse, write discarded.
      d0 = done_cnt[0];
      e0 = err_cnt[0];
      tx_buf[0] = 8'h04;
      tx_buf[1] = 8'hF0;
      run_frame(0, 1, 4);
      check("partial done", 32'(done_cnt[0] - d0), 1);
      check("partial err", 32'(err_cnt[0] - e0), 1);
      check("partial writes", 32'(wlog.size()), 0);
      tx_buf[0] = 8'h84;
      tx_buf[1] = 8'hFF;
      run_frame(0, 2, 0);
      check("partial reg4 unchanged", 32'(rx_buf[1]), 32'h21);

      // Another slave's CS value: clocks must be ignored entirely.
      d0     = done_cnt[0];
      e0     = err_cnt[0];
      oe_low = 0;
      cs[0]  = 3'd6;
      xfer(0, 8'h85, 8, r);
      check("cs6 miso", 32'(r), 0);
      check("cs6 miso_oe low", 32'(oe_low), 8);
      check("cs6 done", 32'(done_cnt[0] - d0), 0);
      check("cs6 err", 32'(err_cnt[0] - e0), 0);
      check("cs6 writes", 32'(wlog.size()), 0);
      cs[0] = 3'd0;
      #200;

      // Reset in the middle of a write frame.
      d0    = done_cnt[3];
      cs[3] = 3'd7;
      xfer(3, 8'h01, 8, r);
      xfer(3, 8'h77, 8, r);
      xfer(3, 8'h12, 4, r);
      #100;
      check("midreset first write count", 32'(wlog.size()), 1);
      if (wlog.size() > 0) check("midreset first write", 32'(wlog[0]), 32'({2'd3, 3'd1, 8'h77}));
      presetn = 1'b0;
      #20;
      check_idle(3, "midreset");
      cs[3]   = 3'd0;
      sclk[3] = 1'b1;
      #50;
      @(negedge pclk);
      presetn = 1'b1;
      #200;
      check("midreset no done", 32'(done_cnt[3] - d0), 0);
      tx_buf[0] = 8'h81;
      tx_buf[1] = 8'hFF;
      run_frame(3, 2, 0);
      check("midreset reg1 reset", 32'(rx_buf[1]), 32'h21);
      check("midreset read done", 32'(done_cnt[3] - d0), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
